// File: rtl/cpu_pkg.sv
// Shared widths, typedefs and constants for the 8-bit core's register file and write-back path.
package cpu_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int REG_ZERO = 0;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB -> write-back/regfile bus; commitCount exists only with WB_COMMIT_COUNT_EN.
interface wb_regfile_if #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W
);
   logic              memRd;
   logic              regWr;
   logic [DATA_W-1:0] memReadData;
   logic [DATA_W-1:0] aluRes;
   logic [ADDR_W-1:0] rd;
   logic [ADDR_W-1:0] rs1;
   logic [ADDR_W-1:0] rs2;
   logic [DATA_W-1:0] rdData1;
   logic [DATA_W-1:0] rdData2;
   logic [DATA_W-1:0] wbData;
   logic [ADDR_W-1:0] wbRd;
   logic              wbValid;
`ifdef WB_COMMIT_COUNT_EN
   logic [15:0]       commitCount;
`endif

   modport master (
      output memRd, regWr, memReadData, aluRes, rd, rs1, rs2,
      input  rdData1, rdData2, wbData, wbRd, wbValid
`ifdef WB_COMMIT_COUNT_EN
      , input commitCount
`endif
   );

   modport slave (
      input  memRd, regWr, memReadData, aluRes, rd, rs1, rs2,
      output rdData1, rdData2, wbData, wbRd, wbValid
`ifdef WB_COMMIT_COUNT_EN
      , output commitCount
`endif
   );
endinterface

// File: rtl/regfile_core.sv
// Register storage: synchronous clear/write, raw combinational read ports (no bypass or masking).
module regfile_core #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int NUM_RD = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           we,
   input  logic [ADDR_W-1:0]              waddr,
   input  logic [DATA_W-1:0]              wdata,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]  raddr,
   output logic [NUM_RD-1:0][DATA_W-1:0]  rdata
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] regs;

   always_ff @(posedge clk) begin
      if (!rst)    regs        <= '0;
      else if (we) regs[waddr] <= wdata;
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      assign rdata[p] = regs[raddr[p]];
   end
endmodule

// File: rtl/wb_regfile.sv
// Write-back mux + register file with R0 masking, same-cycle bypass and reset forcing.
// Optional commit counter enabled by WB_COMMIT_COUNT_EN.
module wb_regfile #(
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int ADDR_W   = cpu_pkg::ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic         clk,
   input  logic         rst,
   wb_regfile_if.slave  bus
);
   import cpu_pkg::*;

   localparam logic [ADDR_W-1:0] R0 = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0]             wb_data;
   logic                          wb_valid;
   logic [1:0][ADDR_W-1:0]        rs_a;
   logic [1:0][DATA_W-1:0]        raw;
   logic [1:0][DATA_W-1:0]        rd_q;

   assign wb_data  = bus.memRd ? bus.memReadData : bus.aluRes;
   // Reset gates wbValid so a colliding write never reaches storage or the bypass.
   assign wb_valid = rst & bus.regWr & ~((ZERO_REG != 0) && (bus.rd == R0));
   assign rs_a     = {bus.rs2, bus.rs1};

   regfile_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(2)) u_core (
      .clk   (clk),
      .rst   (rst),
      .we    (wb_valid),
      .waddr (bus.rd),
      .wdata (wb_data),
      .raddr (rs_a),
      .rdata (raw)
   );

   for (genvar p = 0; p < 2; p++) begin : g_port
      always_comb begin
         rd_q[p] = raw[p];
         if (!rst)                                     rd_q[p] = '0;
         else if ((ZERO_REG != 0) && (rs_a[p] == R0))  rd_q[p] = '0;
         else if (wb_valid && (rs_a[p] == bus.rd))     rd_q[p] = wb_data;
      end
   end

   assign bus.rdData1 = rd_q[0];
   assign bus.rdData2 = rd_q[1];
   assign bus.wbData  = wb_data;
   assign bus.wbRd    = bus.rd;
   assign bus.wbValid = wb_valid;

`ifdef WB_COMMIT_COUNT_EN
   logic [15:0] commit_cnt;

   always_ff @(posedge clk) begin
      if (!rst)                                   commit_cnt <= '0;
      else if (wb_valid && commit_cnt != 16'hFFFF) commit_cnt <= commit_cnt + 16'd1;
   end

   assign bus.commitCount = commit_cnt;
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: ZERO_REG=1 and ZERO_REG=0 instances share stimulus; array-based reference model.
module tb_wb_regfile;
  import cpu_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      memRd, regWr;
  data_t     memReadData, aluRes;
  reg_addr_t rd, rs1, rs2;

  always #5 clk = ~clk;

  wb_regfile_if i0 ();
  wb_regfile_if i1 ();

  assign i0.memRd = memRd;       assign i1.memRd = memRd;
  assign i0.regWr = regWr;       assign i1.regWr = regWr;
  assign i0.memReadData = memReadData; assign i1.memReadData = memReadData;
  assign i0.aluRes = aluRes;     assign i1.aluRes = aluRes;
  assign i0.rd = rd;             assign i1.rd = rd;
  assign i0.rs1 = rs1;           assign i1.rs1 = rs1;
  assign i0.rs2 = rs2;           assign i1.rs2 = rs2;

  wb_regfile #(.ZERO_REG(0)) u_z0 (.clk(clk), .rst(rst), .bus(i0));
  wb_regfile #(.ZERO_REG(1)) u_z1 (.clk(clk), .rst(rst), .bus(i1));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model state, index 0 -> ZERO_REG=0 instance, 1 -> ZERO_REG=1 instance
  data_t       m [2][8];
  int unsigned cnt [2];

  function automatic logic vld(input int z);
    return rst && regWr && !(z != 0 && rd == 0);
  endfunction

  function automatic data_t wbv();
    return memRd ? memReadData : aluRes;
  endfunction

  function automatic data_t rdv(input int z, input reg_addr_t s);
    if (!rst)                return 8'h00;
    if (z != 0 && s == 0)    return 8'h00;
    if (vld(z) && s == rd)   return wbv();
    return m[z][s];
  endfunction

  task automatic check_all();
    chk("z0_rd1",  i0.rdData1, rdv(0, rs1));
    chk("z0_rd2",  i0.rdData2, rdv(0, rs2));
    chk("z0_wbd",  i0.wbData,  wbv());
    chk("z0_wbrd", i0.wbRd,    rd);
    chk("z0_vld",  i0.wbValid, vld(0));
    chk("z1_rd1",  i1.rdData1, rdv(1, rs1));
    chk("z1_rd2",  i1.rdData2, rdv(1, rs2));
    chk("z1_wbd",  i1.wbData,  wbv());
    chk("z1_wbrd", i1.wbRd,    rd);
    chk("z1_vld",  i1.wbValid, vld(1));
`ifdef WB_COMMIT_COUNT_EN
    chk("z0_cnt", i0.commitCount, cnt[0]);
    chk("z1_cnt", i1.commitCount, cnt[1]);
`endif
  endtask

  task automatic update();
    for (int z = 0; z < 2; z++) begin
      if (!rst) begin
        for (int k = 0; k < 8; k++) m[z][k] = 8'h00;
        cnt[z] = 0;
      end else if (vld(z)) begin
        m[z][rd] = wbv();
        if (cnt[z] < 32'd65535) cnt[z]++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic drive(input logic r, input logic mr, input logic w, input data_t md,
                       input data_t ar, input reg_addr_t d, input reg_addr_t s1, input reg_addr_t s2);
    rst = r; memRd = mr; regWr = w; memReadData = md; aluRes = ar; rd = d; rs1 = s1; rs2 = s2;
  endtask

  initial begin
    cnt[0] = 0; cnt[1] = 0;
    for (int k = 0; k < 8; k++) begin m[0][k] = 8'h00; m[1][k] = 8'h00; end

    // reset held two cycles with a write request pending
    drive(1'b0, 1'b0, 1'b1, 8'hEE, 8'hDD, 3'd3, 3'd0, 3'd0);
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 8; s++) begin
        rs1 = reg_addr_t'(s); rs2 = reg_addr_t'(7 - s);
        #1;
        chk("rst_rd1_z0", i0.rdData1, 8'h00);
        chk("rst_rd2_z1", i1.rdData2, 8'h00);
        chk("rst_vld_z0", i0.wbValid, 1'b0);
      end
      tick();
    end

    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0);
    for (int s = 0; s < 8; s++) begin
      rs1 = reg_addr_t'(s); rs2 = reg_addr_t'(s);
      #1;
      chk("post_rst_z0", i0.rdData1, 8'h00);
      chk("post_rst_z1", i1.rdData2, 8'h00);
    end
    tick();

    // ALU select
    drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h3C, 3'd5, 3'd0, 3'd0);
    tick();
    regWr = 1'b0; rs1 = 3'd5; #1;
    chk("alu_sel_z1", i1.rdData1, 8'h3C);
    chk("alu_sel_z0", i0.rdData1, 8'h3C);
    tick();

    // memory select
    drive(1'b1, 1'b1, 1'b1, 8'hA7, 8'h00, 3'd5, 3'd0, 3'd0);
    tick();
    regWr = 1'b0; rs1 = 3'd5; #1;
    chk("mem_sel", i1.rdData1, 8'hA7);
    tick();

    // bypass
    drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h11, 3'd2, 3'd0, 3'd0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h55, 3'd2, 3'd2, 3'd2);
    #1;
    chk("byp_rd1", i1.rdData1, 8'h55);
    chk("byp_rd2", i1.rdData2, 8'h55);
    tick();
    regWr = 1'b0; #1;
    chk("byp_after", i1.rdData1, 8'h55);
    tick();

    // zero register handling
    drive(1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 3'd0, 3'd0, 3'd0);
    #1;
    chk("zr_vld_z1", i1.wbValid, 1'b0);
    chk("zr_rd_z1",  i1.rdData1, 8'h00);
    chk("zr_vld_z0", i0.wbValid, 1'b1);
    tick();
    regWr = 1'b0; #1;
    chk("zr_after_z1", i1.rdData1, 8'h00);
    chk("zr_after_z0", i0.rdData1, 8'hFF);
    tick();

    // write colliding with reset is lost
    drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h99, 3'd4, 3'd4, 3'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h77, 3'd4, 3'd4, 3'd4);
    #1;
    chk("coll_vld", i1.wbValid, 1'b0);
    chk("coll_rd",  i1.rdData1, 8'h00);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd4, 3'd4, 3'd4);
    #1;
    chk("coll_after_z1", i1.rdData1, 8'h00);
    chk("coll_after_z0", i0.rdData2, 8'h00);
    tick();

`ifdef WB_COMMIT_COUNT_EN
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0);
    tick();
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 1'b0, (i < 10), 8'h00, 8'(i), reg_addr_t'(i % 7 + 1), 3'd1, 3'd2);
      tick();
    end
    #1;
    chk("cnt10_z1", i1.commitCount, 16'd10);
    chk("cnt10_z0", i0.commitCount, 16'd10);
`endif

    // randomized traffic, occasional reset, biased toward bypass hits
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 20) != 0, 1'($urandom), ($urandom % 4) != 0,
            8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      if ($urandom % 3 == 0) rs1 = rd;
      if ($urandom % 3 == 0) rs2 = rd;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural register file for the 8-bit pipelined core.
- Consumes the MEM/WB pipeline register outputs: write-back select, write enable, memory read data, ALU result and destination register.
- Commits the selected result into an 8-entry register file and serves two combinational read ports to the decode stage, with same-cycle write-through bypass.
- Exports the write-back value and destination for forwarding logic.

Parameters:
- DATA_W, 8, register and data width in bits.
- ADDR_W, 3, register address width; depth = 2**ADDR_W.
- ZERO_REG, 1, 1 = R0 reads as zero and writes to it are discarded; 0 = R0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- memRd  in  1  write-back select: 1 = memReadData, 0 = aluRes.
- regWr  in  1  register write enable from MEM/WB.
- memReadData  in  DATA_W  load data from MEM/WB.
- aluRes  in  DATA_W  ALU result from MEM/WB.
- rd  in  ADDR_W  destination register from MEM/WB.
- rs1  in  ADDR_W  read port 1 address (decode stage).
- rs2  in  ADDR_W  read port 2 address (decode stage).
- rdData1  out  DATA_W  read port 1 data.
- rdData2  out  DATA_W  read port 2 data.
- wbData  out  DATA_W  selected write-back value (combinational).
- wbRd  out  ADDR_W  write-back destination (= rd).
- wbValid  out  1  effective write this cycle.

Behaviour:
- wbData = memRd ? memReadData : aluRes. Pure mux with no arithmetic and no width change.
- wbValid = regWr & ~(ZERO_REG & (rd == 0)).
- Write: on the rising clk edge with rst = 1 and wbValid = 1, regs[rd] <= wbData. Latency is one edge; the value is architecturally visible from the next cycle.
- Read: rdDataN is combinational.
  - If ZERO_REG and rsN == 0, the result is 0.
  - Else if wbValid and rsN == rd, the result is wbData (write-through bypass in the same cycle).
  - Else the result is regs[rsN].
- Both read ports are independent. rs1 == rs2 == rd with wbValid returns wbData on both.
- Reset: at a clk edge with rst = 0, all regs clear to 0, including R0 when ZERO_REG = 0. Any write requested in that cycle is dropped.
- While rst = 0, the outputs are forced as follows: rdData1, rdData2 = 0; wbValid = 0; wbData and wbRd still follow their inputs.
- Reset mid-operation: a write asserted in the same cycle as reset is lost, and the first cycle after reset reads 0 everywhere.
- Back-to-back writes to the same rd: the last one wins. Each write is visible through bypass in its own cycle.
- There are no X propagation paths. Every output is defined whenever its inputs are known.

Optional Feature:
- Macro WB_COMMIT_COUNT_EN.
- When defined: add output commitCount (16 bits). It clears on reset and increments by 1 on each clock edge where wbValid = 1. It saturates at 16'hFFFF without wrap.
- When undefined: the port and counter are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package (cpu_pkg) holds:
  - DATA_W and ADDR_W constants.
  - the reg_addr_t and data_t typedefs.
  - the localparam REG_ZERO = 0.
- One natural sub-module, regfile_core: storage array, synchronous write, raw combinational reads.
- wb_regfile wraps regfile_core and adds the write-back mux, zero-register masking, bypass, reset forcing and the optional counter.

Test Plan:
- Reset: hold rst = 0 for 2 cycles, then release. All rs1/rs2 values 0..7 read 8'h00, and wbValid = 0 during reset.
- Write-back select:
  - memRd = 0, aluRes = 8'h3C, rd = 5, regWr = 1 for one cycle. Next cycle rs1 = 5 reads 8'h3C.
  - Repeat with memRd = 1, memReadData = 8'hA7. Next cycle rs1 = 5 reads 8'hA7.
- Bypass: regs[2] = 8'h11, then write rd = 2 with aluRes = 8'h55 while rs1 = rs2 = 2. Both ports show 8'h55 in the same cycle, and 8'h55 remains after the edge.
- Zero register: with ZERO_REG = 1, write rd = 0 with aluRes = 8'hFF. wbValid = 0 and rs1 = 0 reads 8'h00. With ZERO_REG = 0, the same stimulus reads 8'hFF on the next cycle.
- Reset collision: regs[4] = 8'h99, then assert rst = 0 in the same cycle as a write of 8'h77 to rd = 4. After release, rs1 = 4 reads 8'h00.
- Counter (WB_COMMIT_COUNT_EN): 10 valid writes plus 3 with regWr = 0 give commitCount = 10. Preload near 16'hFFFF: it holds at 16'hFFFF after further writes.
